// File: rtl/mips_single_cycle.sv
// Single-cycle 32-bit MIPS subset: fetch, decode, execute and retire one instruction per clk.
// Memory sizes must be powers of two so byte addresses wrap by truncation.

module mips_bytemem #(
  parameter int SIZE = 1024
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int AW = $clog2(SIZE);

  logic [7:0]           mem_array [0:SIZE-1];
  logic [3:0][AW-1:0]   idx;
  logic                 unused_addr;

  assign unused_addr = ^addr_i[31:AW];

  // Each byte lane wraps on its own, so a word straddling the top of memory wraps to byte 0.
  always_comb begin
    idx     = '0;
    rdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      idx[k]           = addr_i[AW-1:0] + AW'(k);
      rdata_o[8*k +: 8] = mem_array[idx[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) mem_array[idx[k]] <= wdata_i[8*k +: 8];
    end
  end
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] file_array [0:31];

  // $0 is forced at the read port, so a stale file_array[0] can never leak out.
  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : file_array[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : file_array[ra2_i];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) file_array[wa_i] <= wd_i;
  end
endmodule

module mips_single_cycle #(
  parameter int IMEM_BYTES = 1024,
  parameter int DMEM_BYTES = 1024
) (
  input  logic clk,
  input  logic rst
);
  logic [31:0] pc_q, pc_d, pc, pc_plus4;
  logic [31:0] instr, simm, rs_val, rt_val, alu, ld_data, rfile_wd, dm_addr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rf_wa;
  logic        rf_we, dm_we, is_lw;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign simm     = {{16{instr[15]}}, instr[15:0]};
  assign dm_addr  = {alu[31:2], 2'b00};
  assign is_lw    = (opcode == 6'd35);
  assign rfile_wd = is_lw ? ld_data : alu;

  mips_bytemem #(.SIZE(IMEM_BYTES)) InstrMem (
    .clk(clk), .we_i(1'b0), .addr_i(pc_q), .wdata_i(32'd0), .rdata_o(instr)
  );

  // Writes are qualified by rst so nothing commits on an edge taken while in reset.
  mips_bytemem #(.SIZE(DMEM_BYTES)) DatMem (
    .clk(clk), .we_i(dm_we & rst), .addr_i(dm_addr), .wdata_i(rt_val), .rdata_o(ld_data)
  );

  mips_regfile RegFile (
    .clk(clk), .we_i(rf_we & rst), .wa_i(rf_wa), .wd_i(rfile_wd),
    .ra1_i(instr[25:21]), .ra2_i(instr[20:16]), .rd1_o(rs_val), .rd2_o(rt_val)
  );

  always_comb begin
    alu   = '0;
    rf_we = 1'b0;
    rf_wa = instr[20:16];
    dm_we = 1'b0;
    pc_d  = pc_plus4;
    case (opcode)
      6'd0: begin
        rf_wa = instr[15:11];
        rf_we = 1'b1;
        case (funct)
          6'd32:   alu = rs_val + rt_val;
          6'd34:   alu = rs_val - rt_val;
          6'd36:   alu = rs_val & rt_val;
          6'd37:   alu = rs_val | rt_val;
          6'd42:   alu = {31'd0, $signed(rs_val) < $signed(rt_val)};
          default: rf_we = 1'b0;
        endcase
      end
      6'd9:  begin alu = rs_val + simm; rf_we = 1'b1; end
      6'd35: begin alu = rs_val + simm; rf_we = 1'b1; end
      6'd43: begin alu = rs_val + simm; dm_we = 1'b1; end
      6'd4:  if (rs_val == rt_val) pc_d = pc_plus4 + {simm[29:0], 2'b00};
      6'd5:  if (rs_val != rt_val) pc_d = pc_plus4 + {simm[29:0], 2'b00};
      6'd2:  pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else      pc_q <= pc_d;
  end
endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: preloads state hierarchically, runs programs, and
// compares against an instruction-level reference model of the architecture.

module tb_mips_single_cycle;
  localparam int IMEM = 1024;
  localparam int DMEM = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_single_cycle #(.IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM)) dut (.clk(clk), .rst(rst));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  m_im [IMEM];
  logic [7:0]  m_dm [DMEM];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [31:0] exp_wd, obs_wd;
  bit          exp_wr;
  logic [31:0] prog [$];

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  // Architectural reference: one instruction per call, straight from the ISA rules.
  task automatic m_step(output logic [31:0] wd, output bit wr);
    logic [31:0] ins, a, b, s, ea, npc;
    int dst;
    for (int k = 0; k < 4; k++) ins[8*k +: 8] = m_im[(m_pc + k) % IMEM];
    a = m_rf[ins[25:21]];
    b = m_rf[ins[20:16]];
    s = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 32'd4;
    wd = 0; wr = 0; dst = ins[20:16];
    case (ins[31:26])
      6'd0: begin
        dst = ins[15:11]; wr = 1;
        case (ins[5:0])
          6'd32: wd = a + b;
          6'd34: wd = a - b;
          6'd36: wd = a & b;
          6'd37: wd = a | b;
          6'd42: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 0;
        endcase
      end
      6'd9:  begin wd = a + s; wr = 1; end
      6'd35: begin
        ea = ((a + s) & 32'hFFFF_FFFC) % DMEM;
        wd = {m_dm[ea+3], m_dm[ea+2], m_dm[ea+1], m_dm[ea]}; wr = 1;
      end
      6'd43: begin
        ea = ((a + s) & 32'hFFFF_FFFC) % DMEM;
        for (int k = 0; k < 4; k++) m_dm[ea+k] = b[8*k +: 8];
      end
      6'd4: if (a == b) npc = m_pc + 32'd4 + (s << 2);
      6'd5: if (a != b) npc = m_pc + 32'd4 + (s << 2);
      6'd2: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (wr && dst != 0) m_rf[dst] = wd;
    m_pc = npc;
  endtask

  task automatic clear_all();
    for (int i = 0; i < IMEM; i++) begin dut.InstrMem.mem_array[i] <= 8'd0; m_im[i] = 8'd0; end
    for (int i = 0; i < DMEM; i++) begin dut.DatMem.mem_array[i] <= 8'd0; m_dm[i] = 8'd0; end
    for (int i = 0; i < 32; i++) begin dut.RegFile.file_array[i] <= 32'd0; m_rf[i] = 32'd0; end
    m_pc = 32'd0;
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    dut.RegFile.file_array[r] <= v;
    m_rf[r] = (r == 0) ? 32'd0 : v;
  endtask

  task automatic load_prog(input int base);
    int a;
    for (int w = 0; w < prog.size(); w++)
      for (int k = 0; k < 4; k++) begin
        a = (base + 4*w + k) % IMEM;
        dut.InstrMem.mem_array[a] <= prog[w][8*k +: 8];
        m_im[a] = prog[w][8*k +: 8];
      end
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    prog.delete();
  endtask

  task automatic run_start();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    #1;
    m_step(exp_wd, exp_wr);
    obs_wd = dut.rfile_wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] pre1;
    begin_test();
    for (int r = 1; r < 8; r++) set_reg(r, $urandom);
    pre1 = m_rf[1];
    prog.push_back(enc_i(9, 1, 1, 1));
    load_prog(0);
    #1;
    n_cmp++; if (dut.pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc_async: got %h want 0", dut.pc); end
    @(posedge clk); #1;
    n_cmp++; if (dut.pc !== 32'd0) begin n_bad++; $display("FAIL reset_pc_held: got %h want 0", dut.pc); end
    run_start(); #1;
    for (int r = 1; r < 8; r++) begin
      n_cmp++;
      if (dut.RegFile.file_array[r] !== m_rf[r]) begin
        n_bad++; $display("FAIL reset_preload r%0d: got %h want %h", r, dut.RegFile.file_array[r], m_rf[r]);
      end
    end
    n_cmp++; if (dut.opcode !== 6'd9) begin n_bad++; $display("FAIL reset_first_fetch: got op %0d want 9", dut.opcode); end
    step();
    n_cmp++; if (dut.RegFile.file_array[1] !== pre1 + 32'd1) begin
      n_bad++; $display("FAIL reset_first_exec: got %h want %h", dut.RegFile.file_array[1], pre1 + 32'd1); end
    n_cmp++; if (dut.pc !== 32'd4) begin n_bad++; $display("FAIL reset_pc_after1: got %h want 4", dut.pc); end
  endtask

  task automatic test_alu();
    logic [31:0] a, b;
    logic [31:0] k_exp [6];
    k_exp = '{32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd0};
    for (int it = 0; it < 6; it++) begin
      begin_test();
      a = (it == 0) ? 32'd5 : (it == 2) ? 32'h8000_0000 : $urandom;
      b = (it == 0) ? 32'd3 : (it == 1) ? a : (it == 2) ? 32'd1 : $urandom;
      set_reg(1, a); set_reg(2, b);
      prog.push_back(enc_r(32, 1, 2, 3));
      prog.push_back(enc_r(34, 1, 2, 4));
      prog.push_back(enc_r(36, 1, 2, 5));
      prog.push_back(enc_r(37, 1, 2, 6));
      prog.push_back(enc_r(42, 2, 1, 7));
      prog.push_back(enc_r(42, 1, 2, 8));
      load_prog(0);
      run_start();
      for (int s = 0; s < 6; s++) begin
        step();
        n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL alu_wd it%0d op%0d: got %h want %h", it, s, obs_wd, exp_wd); end
        if (it == 0) begin
          n_cmp++; if (obs_wd !== k_exp[s]) begin n_bad++; $display("FAIL alu_fixed op%0d: got %h want %h", s, obs_wd, k_exp[s]); end
        end
      end
      for (int r = 3; r <= 8; r++) begin
        n_cmp++; if (dut.RegFile.file_array[r] !== m_rf[r]) begin
          n_bad++; $display("FAIL alu_reg it%0d r%0d: got %h want %h", it, r, dut.RegFile.file_array[r], m_rf[r]); end
      end
      n_cmp++; if (dut.pc !== 32'd24) begin n_bad++; $display("FAIL alu_pc: got %h want 18", dut.pc); end
    end
  endtask

  task automatic test_addiu();
    int dst, src, imm;
    begin_test();
    dut.RegFile.file_array[0] <= 32'hDEAD_BEEF;
    set_reg(1, $urandom);
    prog.push_back(enc_i(9, 0, 5, -1));
    prog.push_back(enc_i(9, 1, 0, 7));
    prog.push_back(enc_r(32, 0, 0, 6));
    for (int i = 0; i < 6; i++) begin
      dst = $urandom_range(2, 7); src = $urandom_range(0, 7); imm = $urandom_range(0, 65535);
      if (dst == 5 || dst == 6) dst = 7;
      prog.push_back(enc_i(9, src, dst, imm));
    end
    load_prog(0);
    run_start();
    for (int s = 0; s < 9; s++) begin
      step();
      n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL addiu_wd step%0d: got %h want %h", s, obs_wd, exp_wd); end
    end
    n_cmp++; if (dut.RegFile.file_array[5] !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL addiu_neg1: got %h want ffffffff", dut.RegFile.file_array[5]); end
    n_cmp++; if (dut.RegFile.file_array[0] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL r0_write_discard: got %h want deadbeef", dut.RegFile.file_array[0]); end
    n_cmp++; if (dut.RegFile.file_array[6] !== 32'd0) begin
      n_bad++; $display("FAIL r0_reads_zero: got %h want 0", dut.RegFile.file_array[6]); end
    for (int r = 1; r < 8; r++) begin
      n_cmp++; if (dut.RegFile.file_array[r] !== m_rf[r]) begin
        n_bad++; $display("FAIL addiu_reg r%0d: got %h want %h", r, dut.RegFile.file_array[r], m_rf[r]); end
    end
  endtask

  task automatic test_mem();
    int bad;
    logic [7:0] k_b [4];
    k_b = '{8'h05, 8'h00, 8'h00, 8'h00};
    begin_test();
    set_reg(1, 32'd5);
    prog.push_back(enc_i(43, 0, 1, 4));
    prog.push_back(enc_i(35, 0, 6, 4));
    load_prog(0);
    run_start();
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (dut.DatMem.mem_array[4+k] !== k_b[k]) begin
        n_bad++; $display("FAIL sw_byte%0d: got %h want %h", 4+k, dut.DatMem.mem_array[4+k], k_b[k]); end
    end
    step();
    n_cmp++; if (obs_wd !== 32'd5) begin n_bad++; $display("FAIL lw_wd: got %h want 5", obs_wd); end
    n_cmp++; if (dut.RegFile.file_array[6] !== 32'd5) begin
      n_bad++; $display("FAIL lw_reg: got %h want 5", dut.RegFile.file_array[6]); end

    begin_test();
    for (int r = 1; r < 8; r++) set_reg(r, $urandom);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) prog.push_back(enc_i(43, 2, $urandom_range(1, 7), $urandom_range(0, 127) - 64));
      else                           prog.push_back(enc_i(35, 2, $urandom_range(3, 7), $urandom_range(0, 127) - 64));
    end
    load_prog(0);
    run_start();
    for (int s = 0; s < 12; s++) begin
      step();
      if (exp_wr) begin
        n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL mem_wd step%0d: got %h want %h", s, obs_wd, exp_wd); end
      end
    end
    bad = 0;
    for (int i = 0; i < DMEM; i++) if (dut.DatMem.mem_array[i] !== m_dm[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mem_image: got %0d differing bytes want 0", bad); end
    for (int r = 1; r < 8; r++) begin
      n_cmp++; if (dut.RegFile.file_array[r] !== m_rf[r]) begin
        n_bad++; $display("FAIL mem_reg r%0d: got %h want %h", r, dut.RegFile.file_array[r], m_rf[r]); end
    end
  endtask

  task automatic test_branch();
    int ops [3]  = '{4, 5, 4};
    int imms [3] = '{2, 2, -1};
    logic [31:0] k_pc [3];
    int op;
    k_pc = '{32'h1C, 32'h14, 32'h10};
    for (int it = 0; it < 11; it++) begin
      begin_test();
      set_reg(1, $urandom);
      set_reg(2, ($urandom_range(0, 1) == 1) ? m_rf[1] : $urandom);
      op = (it < 3) ? ops[it] : $urandom_range(4, 5);
      prog.push_back((it < 3) ? enc_i(op, 1, 1, imms[it]) : enc_i(op, 1, 2, $urandom_range(0, 15) - 8));
      load_prog(16);
      run_start();
      for (int s = 0; s < 4; s++) step();
      n_cmp++; if (dut.pc !== 32'h10) begin n_bad++; $display("FAIL br_reach it%0d: got %h want 10", it, dut.pc); end
      step();
      n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL br_model it%0d: got %h want %h", it, dut.pc, m_pc); end
      if (it < 3) begin
        n_cmp++; if (dut.pc !== k_pc[it]) begin n_bad++; $display("FAIL br_fixed it%0d: got %h want %h", it, dut.pc, k_pc[it]); end
      end
      if (it == 2) begin
        step();
        n_cmp++; if (dut.pc !== 32'h10) begin n_bad++; $display("FAIL br_selfloop: got %h want 10", dut.pc); end
      end
    end
  endtask

  task automatic test_jump_wrap();
    begin_test();
    prog.push_back(enc_j(32'h10));
    load_prog(32);
    run_start();
    for (int s = 0; s < 9; s++) step();
    n_cmp++; if (dut.pc !== 32'h40) begin n_bad++; $display("FAIL j_fixed: got %h want 40", dut.pc); end

    begin_test();
    prog.push_back(enc_j($urandom_range(0, 32'h3FF_FFFF)));
    load_prog(0);
    run_start();
    step();
    n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL j_random: got %h want %h", dut.pc, m_pc); end

    // Branch backwards past zero: pc wraps mod 2^32 and fetch wraps mod IMEM.
    begin_test();
    prog.push_back(enc_i(4, 0, 0, -8));
    load_prog(16);
    prog.delete();
    prog.push_back(enc_i(9, 0, 9, 16'h55));
    load_prog(IMEM - 8);
    run_start();
    for (int s = 0; s < 5; s++) step();
    n_cmp++; if (dut.pc !== 32'hFFFF_FFF4) begin n_bad++; $display("FAIL pc_neg: got %h want fffffff4", dut.pc); end
    step(); step();
    n_cmp++; if (dut.RegFile.file_array[9] !== 32'h55) begin
      n_bad++; $display("FAIL fetch_wrap: got %h want 55", dut.RegFile.file_array[9]); end
    step();
    n_cmp++; if (dut.pc !== 32'd0) begin n_bad++; $display("FAIL pc_wrap: got %h want 0", dut.pc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r3;
    begin_test();
    prog.push_back(enc_i(9, 3, 3, 1));
    prog.push_back(enc_i(43, 0, 3, 16'h40));
    prog.push_back(enc_j(0));
    load_prog(0);
    run_start();
    for (int s = 0; s < 7; s++) step();
    n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL mid_pre_pc: got %h want %h", dut.pc, m_pc); end
    #2; rst = 1'b0; #1;
    n_cmp++; if (dut.pc !== 32'd0) begin n_bad++; $display("FAIL mid_rst_async: got %h want 0", dut.pc); end
    m_pc = 32'd0;
    r3 = m_rf[3];
    @(posedge clk); @(negedge clk);
    n_cmp++; if (dut.RegFile.file_array[3] !== r3) begin
      n_bad++; $display("FAIL mid_rst_nowrite_reg: got %h want %h", dut.RegFile.file_array[3], r3); end
    prog.delete();
    prog.push_back(enc_i(43, 0, 3, 16'h80));
    load_prog(0);
    @(posedge clk); @(negedge clk);
    n_cmp++; if (dut.DatMem.mem_array[8'h80] !== 8'd0) begin
      n_bad++; $display("FAIL mid_rst_nowrite_mem: got %h want 0", dut.DatMem.mem_array[8'h80]); end
    rst = 1'b1;
    step(); step();
    n_cmp++; if (dut.DatMem.mem_array[8'h80] !== m_dm[8'h80]) begin
      n_bad++; $display("FAIL mid_resume_mem: got %h want %h", dut.DatMem.mem_array[8'h80], m_dm[8'h80]); end
    n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL mid_resume_pc: got %h want %h", dut.pc, m_pc); end
  endtask

  task automatic test_random_prog();
    int fns [6] = '{32, 34, 36, 37, 42, 0};
    int bad;
    begin_test();
    for (int r = 1; r < 8; r++) set_reg(r, ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3));
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 7))
        0, 1: prog.push_back(enc_r(fns[$urandom_range(0, 5)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        2:    prog.push_back(enc_i(9,  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
        3:    prog.push_back(enc_i(35, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
        4:    prog.push_back(enc_i(43, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
        5:    prog.push_back(enc_i($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15) - 8));
        6:    prog.push_back(enc_j($urandom_range(0, 63)));
        default: prog.push_back(enc_i(15, $urandom_range(0, 7), $urandom_range(0, 7), $urandom));
      endcase
    end
    load_prog(0);
    run_start();
    for (int s = 0; s < 80; s++) begin
      step();
      if (exp_wr) begin
        n_cmp++; if (obs_wd !== exp_wd) begin n_bad++; $display("FAIL rnd_wd step%0d: got %h want %h", s, obs_wd, exp_wd); end
      end
      n_cmp++; if (dut.pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc step%0d: got %h want %h", s, dut.pc, m_pc); end
    end
    for (int r = 1; r < 8; r++) begin
      n_cmp++; if (dut.RegFile.file_array[r] !== m_rf[r]) begin
        n_bad++; $display("FAIL rnd_reg r%0d: got %h want %h", r, dut.RegFile.file_array[r], m_rf[r]); end
    end
    bad = 0;
    for (int i = 0; i < DMEM; i++) if (dut.DatMem.mem_array[i] !== m_dm[i]) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rnd_mem_image: got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_addiu();
    test_mem();
    test_branch();
    test_jump_wrap();
    test_reset_mid();
    test_random_prog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
